// File: rtl/c64_kbd_pkg.sv
// c64_kbd_pkg: shared types and constants for the PS/2 to C64 keyboard bridge.
// Contents:
//   rx_state_t    - PS/2 frame receiver states
//   SC_*          - special PS/2 set-2 scancodes
//   kbd_map_t     - {valid, col, row} position of a key in the C64 matrix
//   scancode_map  - PS/2 set-2 (with E0 prefix flag) to C64 matrix lookup
package c64_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_BAT     = 8'hAA;
  localparam logic [7:0] SC_OVR_HI  = 8'hFF;
  localparam logic [7:0] SC_OVR_LO  = 8'h00;
  localparam logic [7:0] SC_RESTORE = 8'h7D;  // with E0 prefix (PgUp)

  typedef struct packed {
    logic       valid;
    logic [2:0] col;   // CIA1 port A bit
    logic [2:0] row;   // CIA1 port B bit
  } kbd_map_t;

  function automatic kbd_map_t key_at(input int col, input int row);
    kbd_map_t m;
    m.valid = 1'b1;
    m.col   = 3'(col);
    m.row   = 3'(row);
    return m;
  endfunction

  // The C64 up-arrow key has no natural PS/2 equivalent, so F8 stands in.
  function automatic kbd_map_t scancode_map(input logic ext, input logic [7:0] code);
    kbd_map_t m;
    m = '0;
    case ({ext, code})
      // column 0: DEL RETURN CRSR-RIGHT F7 F1 F3 F5 CRSR-DOWN
      9'h066, 9'h171: m = key_at(0, 0);
      9'h05A, 9'h15A: m = key_at(0, 1);
      9'h174: m = key_at(0, 2);  9'h083: m = key_at(0, 3);
      9'h005: m = key_at(0, 4);  9'h004: m = key_at(0, 5);
      9'h003: m = key_at(0, 6);  9'h172: m = key_at(0, 7);
      // column 1: 3 W A 4 Z S E LSHIFT
      9'h026: m = key_at(1, 0);  9'h01D: m = key_at(1, 1);
      9'h01C: m = key_at(1, 2);  9'h025: m = key_at(1, 3);
      9'h01A: m = key_at(1, 4);  9'h01B: m = key_at(1, 5);
      9'h024: m = key_at(1, 6);  9'h012: m = key_at(1, 7);
      // column 2: 5 R D 6 C F T X
      9'h02E: m = key_at(2, 0);  9'h02D: m = key_at(2, 1);
      9'h023: m = key_at(2, 2);  9'h036: m = key_at(2, 3);
      9'h021: m = key_at(2, 4);  9'h02B: m = key_at(2, 5);
      9'h02C: m = key_at(2, 6);  9'h022: m = key_at(2, 7);
      // column 3: 7 Y G 8 B H U V
      9'h03D: m = key_at(3, 0);  9'h035: m = key_at(3, 1);
      9'h034: m = key_at(3, 2);  9'h03E: m = key_at(3, 3);
      9'h032: m = key_at(3, 4);  9'h033: m = key_at(3, 5);
      9'h03C: m = key_at(3, 6);  9'h02A: m = key_at(3, 7);
      // column 4: 9 I J 0 M K O N
      9'h046: m = key_at(4, 0);  9'h043: m = key_at(4, 1);
      9'h03B: m = key_at(4, 2);  9'h045: m = key_at(4, 3);
      9'h03A: m = key_at(4, 4);  9'h042: m = key_at(4, 5);
      9'h044: m = key_at(4, 6);  9'h031: m = key_at(4, 7);
      // column 5: + P L - . : @ ,
      9'h079: m = key_at(5, 0);  9'h04D: m = key_at(5, 1);
      9'h04B: m = key_at(5, 2);  9'h04E: m = key_at(5, 3);
      9'h049: m = key_at(5, 4);  9'h052: m = key_at(5, 5);
      9'h054: m = key_at(5, 6);  9'h041: m = key_at(5, 7);
      // column 6: pound * ; HOME RSHIFT = up-arrow /
      9'h05D: m = key_at(6, 0);  9'h05B: m = key_at(6, 1);
      9'h04C: m = key_at(6, 2);  9'h16C: m = key_at(6, 3);
      9'h059: m = key_at(6, 4);  9'h055: m = key_at(6, 5);
      9'h00A: m = key_at(6, 6);  9'h04A: m = key_at(6, 7);
      // column 7: 1 left-arrow CTRL 2 SPACE C= Q RUN/STOP
      9'h016: m = key_at(7, 0);  9'h00E: m = key_at(7, 1);
      9'h014, 9'h114: m = key_at(7, 2);
      9'h01E: m = key_at(7, 3);  9'h029: m = key_at(7, 4);
      9'h011: m = key_at(7, 5);  9'h015: m = key_at(7, 6);
      9'h076: m = key_at(7, 7);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/c64_ps2_keyboard_ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Ports:
//   clk, res_n           - system clock, synchronous active-low reset
//   ps2_clk, ps2_data    - raw asynchronous PS/2 lines
//   byte_valid           - one-cycle pulse, byte_data holds an accepted byte
//   byte_data[7:0]       - last received byte
//   frame_err            - one-cycle pulse on parity/stop/timeout rejection
module ps2_rx
  import c64_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, fall, dat_smp;

  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_d, err_d;

  // The filtered clock only flips after FILTER_LEN consecutive synced samples
  // disagree with it; data is captured at the same moment the fall is seen.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
      dat_smp  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        filt_clk <= clk_sync[1];
        fall     <= ~clk_sync[1];
        dat_smp  <= dat_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  // tmo_q counts cycles since the last falling edge while a frame is open.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q != RX_IDLE && !fall) tmo_d = tmo_q + 1'b1;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_smp) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_smp, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_smp;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_smp && (^{shift_q, par_q})) valid_d = 1'b1;
          else                                 err_d   = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/c64_ps2_keyboard.sv
// c64_ps2_keyboard: PS/2 keyboard to C64 8x8 key matrix for CIA1 port B.
// Ports:
//   clk, res_n          - CIA bus clock, synchronous active-low reset
//   ps2_clk, ps2_data   - raw PS/2 lines
//   col_sel[7:0]        - CIA1 pa_out, low bit selects a column
//   row_n[7:0]          - to CIA1 pb_in, low bit = pressed key in selected column
//   restore_n           - RESTORE key, active low
//   frame_err           - one-cycle pulse on a rejected frame
module c64_ps2_keyboard
  import c64_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] col_sel,
  output logic [7:0] row_n,
  output logic       restore_n,
  output logic       frame_err
);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            rx_err;

  logic [7:0][7:0] key_q, key_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic            restore_q, restore_d;
  kbd_map_t        hit;
  logic [7:0]      row_hit;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .res_n     (res_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (rx_err)
  );

  // Decoder next state. RESTORE is also dropped on a frame error so that a
  // lost break code cannot leave it held.
  always_comb begin
    key_d     = key_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    restore_d = restore_q;
    hit       = scancode_map(ext_q, byte_data);
    if (rx_err) begin
      key_d     = '0;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
      restore_d = 1'b0;
    end else if (byte_valid) begin
      case (byte_data)
        SC_EXT: ext_d = 1'b1;
        SC_BRK: brk_d = 1'b1;
        SC_BAT, SC_OVR_HI, SC_OVR_LO: begin
          key_d     = '0;
          ext_d     = 1'b0;
          brk_d     = 1'b0;
          restore_d = 1'b0;
        end
        default: begin
          if (ext_q && byte_data == SC_RESTORE) restore_d = ~brk_q;
          else if (hit.valid)                   key_d[hit.col][hit.row] = ~brk_q;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  // Rows are formed from the next-state matrix so a matrix update and a
  // col_sel change in the same cycle land in row_n together.
  always_comb begin
    row_hit = '0;
    for (int c = 0; c < 8; c++) begin
      if (!col_sel[c]) row_hit = row_hit | key_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      key_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      restore_q <= 1'b0;
      row_n     <= 8'hFF;
    end else begin
      key_q     <= key_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      restore_q <= restore_d;
      row_n     <= ~row_hit;
    end
  end

  assign restore_n = ~restore_q;
  assign frame_err = rx_err;

endmodule
